// File: rtl/eq_band_mixer_if.sv
// eq_band_mixer_if
//   Groups the band-sample handshake and the mixed-audio result bus of the
//   stereo band mixer.
//   Signals (master = producer of band samples, slave = mixer):
//     vld                    one-cycle pulse, new band samples present
//     band_lft / band_rght   NUM_BANDS packed signed samples, band k at [k*DATA_W +: DATA_W]
//     pot                    NUM_BANDS packed unsigned pots, band k at [k*POT_W +: POT_W]
//     volume                 unsigned master volume
//     busy                   mixing in progress
//     out_vld                one-cycle strobe, aud_out_* / clip_* freshly updated
//     aud_out_lft/rght       signed mixed output, held between strobes
//     clip_lft/rght          saturation seen somewhere in this sample
//     overrun                one-cycle pulse, a vld arrived while busy and was dropped
interface eq_band_mixer_if #(
    parameter int NUM_BANDS = 5,
    parameter int DATA_W    = 16,
    parameter int POT_W     = 12
);
    logic                          vld;
    logic [NUM_BANDS*DATA_W-1:0]   band_lft;
    logic [NUM_BANDS*DATA_W-1:0]   band_rght;
    logic [NUM_BANDS*POT_W-1:0]    pot;
    logic [POT_W-1:0]              volume;
    logic                          busy;
    logic                          out_vld;
    logic signed [DATA_W-1:0]      aud_out_lft;
    logic signed [DATA_W-1:0]      aud_out_rght;
    logic                          clip_lft;
    logic                          clip_rght;
    logic                          overrun;

    modport master (
        output vld, band_lft, band_rght, pot, volume,
        input  busy, out_vld, aud_out_lft, aud_out_rght, clip_lft, clip_rght, overrun
    );

    modport slave (
        input  vld, band_lft, band_rght, pot, volume,
        output busy, out_vld, aud_out_lft, aud_out_rght, clip_lft, clip_rght, overrun
    );
endinterface

// File: rtl/eq_band_mixer.sv
// eq_band_mixer
//   Stereo band mixer: squares each band pot into a gain, scales and sums the
//   bands with saturation, then applies master volume. One multiplier per
//   channel is shared across all bands and the volume step; a separate
//   squarer forms the next band gain one cycle ahead of its use.
//   Ports:
//     clk     system clock, rising edge
//     rst_n   asynchronous active-low reset
//     mix_if  slave side of eq_band_mixer_if (band samples in, audio out)
module eq_band_mixer #(
    parameter int NUM_BANDS = 5,
    parameter int DATA_W    = 16,
    parameter int POT_W     = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    eq_band_mixer_if.slave   mix_if
);
    localparam int IDX_W = $clog2(NUM_BANDS);
    localparam int ACC_W = DATA_W + $clog2(NUM_BANDS) + 1;
    // Shared multiplier width: signed DATA_W operand times {0,POT_W} operand.
    localparam int TP_W  = DATA_W + POT_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BANDS - 1);

    typedef enum logic [2:0] {IDLE, GAIN, MAC, VOL, DONE} state_t;

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;

    logic signed [DATA_W-1:0]  band_l_in [NUM_BANDS];
    logic signed [DATA_W-1:0]  band_r_in [NUM_BANDS];
    logic [POT_W-1:0]          pot_in    [NUM_BANDS];
    logic signed [DATA_W-1:0]  band_l_q  [NUM_BANDS];
    logic signed [DATA_W-1:0]  band_r_q  [NUM_BANDS];
    logic [POT_W-1:0]          pot_q     [NUM_BANDS];
    logic [POT_W-1:0]          vol_q;

    logic [POT_W-1:0]          gain_q;
    logic signed [ACC_W-1:0]   acc_l_q, acc_r_q;
    logic                      clip_l_q, clip_r_q;
    logic signed [DATA_W-1:0]  y_l_q, y_r_q;

    logic signed [DATA_W-1:0]  aud_l_q, aud_r_q;
    logic                      clip_out_l_q, clip_out_r_q;
    logic                      out_vld_q, overrun_q;

    logic                      busy, capture, load_gain;
    logic [IDX_W-1:0]          gain_idx;
    logic [2*POT_W-1:0]        pot_ext, pot_sq;
    logic [POT_W-1:0]          gain_next;
    logic [DATA_W:0]           term_l_sat, term_r_sat, sum_l_sat, sum_r_sat;
    logic signed [TP_W-1:0]    mul_a_l, mul_a_r, mul_b, prod_l, prod_r;
    logic signed [ACC_W-1:0]   term_l, term_r;
    logic signed [DATA_W-1:0]  y_l, y_r;

    // Saturate an ACC_W value to DATA_W. Returns {clip, value}: in range when
    // every bit from the DATA_W sign bit upward agrees.
    function automatic logic [DATA_W:0] sat_acc(input logic signed [ACC_W-1:0] x);
        logic [DATA_W:0] r;
        if ((&x[ACC_W-1:DATA_W-1]) || !(|x[ACC_W-1:DATA_W-1])) begin
            r = {1'b0, x[DATA_W-1:0]};
        end else if (x[ACC_W-1]) begin
            r = {1'b1, 1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            r = {1'b1, 1'b0, {(DATA_W-1){1'b1}}};
        end
        return r;
    endfunction

    // Unpack the flat input buses into per-band arrays.
    for (genvar gi = 0; gi < NUM_BANDS; gi++) begin : g_unpack
        assign band_l_in[gi] = mix_if.band_lft[gi*DATA_W +: DATA_W];
        assign band_r_in[gi] = mix_if.band_rght[gi*DATA_W +: DATA_W];
        assign pot_in[gi]    = mix_if.pot[gi*POT_W +: POT_W];
    end

    assign busy    = (state_q == GAIN) || (state_q == MAC) || (state_q == VOL);
    assign capture = mix_if.vld && ((state_q == IDLE) || (state_q == DONE));

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (mix_if.vld) begin
                    state_d = GAIN;
                    idx_d   = '0;
                end
            end
            GAIN: state_d = MAC;
            MAC: begin
                if (idx_q == LAST_IDX) begin
                    state_d = VOL;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            VOL:  state_d = DONE;
            DONE: begin
                if (mix_if.vld) begin
                    state_d = GAIN;
                    idx_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // ---------------- gain squarer ----------------
    // The gain for band idx+1 is formed while band idx is being accumulated,
    // so the squarer and the band multiplier never chain in one cycle.
    assign load_gain = (state_q == GAIN) || ((state_q == MAC) && (idx_q != LAST_IDX));
    assign gain_idx  = ((state_q == MAC) && (idx_q != LAST_IDX)) ? idx_q + IDX_W'(1) : '0;
    assign pot_ext   = {{POT_W{1'b0}}, pot_q[gain_idx]};
    assign pot_sq    = pot_ext * pot_ext;
    assign gain_next = POT_W'(pot_sq >> POT_W);

    // ---------------- shared multipliers ----------------
    // MAC: band * {0,gain}; VOL: saturated sum * {0,volume}.
    assign sum_l_sat = sat_acc(acc_l_q);
    assign sum_r_sat = sat_acc(acc_r_q);

    always_comb begin
        if (state_q == VOL) begin
            mul_a_l = {{(TP_W-DATA_W){sum_l_sat[DATA_W-1]}}, sum_l_sat[DATA_W-1:0]};
            mul_a_r = {{(TP_W-DATA_W){sum_r_sat[DATA_W-1]}}, sum_r_sat[DATA_W-1:0]};
            mul_b   = {{(TP_W-POT_W){1'b0}}, vol_q};
        end else begin
            mul_a_l = {{(TP_W-DATA_W){band_l_q[idx_q][DATA_W-1]}}, band_l_q[idx_q]};
            mul_a_r = {{(TP_W-DATA_W){band_r_q[idx_q][DATA_W-1]}}, band_r_q[idx_q]};
            mul_b   = {{(TP_W-POT_W){1'b0}}, gain_q};
        end
    end

    assign prod_l = mul_a_l * mul_b;
    assign prod_r = mul_a_r * mul_b;

    // A gain of 2^(POT_W-1) is unity, hence the POT_W-1 shift for band terms.
    // The shifted term always fits ACC_W, so the truncation is exact.
    assign term_l     = ACC_W'(prod_l >>> (POT_W - 1));
    assign term_r     = ACC_W'(prod_r >>> (POT_W - 1));
    assign term_l_sat = sat_acc(term_l);
    assign term_r_sat = sat_acc(term_r);

    // Volume never increases magnitude, so y fits DATA_W without saturation.
    assign y_l = DATA_W'(prod_l >>> POT_W);
    assign y_r = DATA_W'(prod_r >>> POT_W);

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            band_l_q     <= '{default: '0};
            band_r_q     <= '{default: '0};
            pot_q        <= '{default: '0};
            vol_q        <= '0;
            gain_q       <= '0;
            acc_l_q      <= '0;
            acc_r_q      <= '0;
            clip_l_q     <= 1'b0;
            clip_r_q     <= 1'b0;
            y_l_q        <= '0;
            y_r_q        <= '0;
            aud_l_q      <= '0;
            aud_r_q      <= '0;
            clip_out_l_q <= 1'b0;
            clip_out_r_q <= 1'b0;
            out_vld_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            overrun_q <= mix_if.vld && busy;
            out_vld_q <= (state_q == DONE);

            if (state_q == DONE) begin
                aud_l_q      <= y_l_q;
                aud_r_q      <= y_r_q;
                clip_out_l_q <= clip_l_q;
                clip_out_r_q <= clip_r_q;
            end

            if (capture) begin
                band_l_q <= band_l_in;
                band_r_q <= band_r_in;
                pot_q    <= pot_in;
                vol_q    <= mix_if.volume;
                acc_l_q  <= '0;
                acc_r_q  <= '0;
                clip_l_q <= 1'b0;
                clip_r_q <= 1'b0;
            end else if (state_q == MAC) begin
                acc_l_q  <= acc_l_q + {{(ACC_W-DATA_W){term_l_sat[DATA_W-1]}}, term_l_sat[DATA_W-1:0]};
                acc_r_q  <= acc_r_q + {{(ACC_W-DATA_W){term_r_sat[DATA_W-1]}}, term_r_sat[DATA_W-1:0]};
                clip_l_q <= clip_l_q | term_l_sat[DATA_W];
                clip_r_q <= clip_r_q | term_r_sat[DATA_W];
            end else if (state_q == VOL) begin
                y_l_q    <= y_l;
                y_r_q    <= y_r;
                clip_l_q <= clip_l_q | sum_l_sat[DATA_W];
                clip_r_q <= clip_r_q | sum_r_sat[DATA_W];
            end

            if (load_gain) begin
                gain_q <= gain_next;
            end
        end
    end

    assign mix_if.busy         = busy;
    assign mix_if.out_vld      = out_vld_q;
    assign mix_if.aud_out_lft  = aud_l_q;
    assign mix_if.aud_out_rght = aud_r_q;
    assign mix_if.clip_lft     = clip_out_l_q;
    assign mix_if.clip_rght    = clip_out_r_q;
    assign mix_if.overrun      = overrun_q;
endmodule

// File: doc/eq_band_mixer.md
# eq_band_mixer

Parametrised stereo band mixer for the equalizer datapath, the next generation of the per-band gain/sum/volume back end. It takes NUM_BANDS filtered band samples per channel plus one gain pot per band. It squares each pot into a gain, scales and accumulates the bands with saturation, then applies master volume. One shared multiplier pair is time-multiplexed per channel across bands, replacing one multiplier per band. It sits between the FIR bank output registers and the audio output path, and raises per-sample clip flags and a one-cycle result strobe.

## Interface
- NUM_BANDS, default 5: number of bands per channel (≥2).
- DATA_W, default 16: signed sample width (band in and audio out).
- POT_W, default 12: unsigned pot / volume width.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- vld  in  1  new band samples present; one-cycle pulse.
- band_lft  in  NUM_BANDS*DATA_W  signed left band samples; band k at [k*DATA_W +: DATA_W].
- band_rght  in  NUM_BANDS*DATA_W  signed right band samples, same packing.
- pot  in  NUM_BANDS*POT_W  unsigned band pots; band k at [k*POT_W +: POT_W].
- volume  in  POT_W  unsigned master volume.
- busy  out  1  mixing in progress.
- out_vld  out  1  one-cycle strobe; new aud_out_* and clip_* valid.
- aud_out_lft, aud_out_rght  out  DATA_W  signed mixed output; held between strobes.
- clip_lft, clip_rght  out  1  saturation occurred in this sample; updated with out_vld.
- overrun  out  1  one-cycle pulse when vld arrives while busy.

## Operation
- FSM states: IDLE, GAIN, MAC, VOL, DONE.
- IDLE:
  - vld=1 snapshots band_lft, band_rght, pot and volume into internal registers.
  - Clears both accumulators and clip flags, sets idx=0, and moves to GAIN.
- Gain for band k: g_k = (pot_k*pot_k) >> POT_W, a POT_W-bit unsigned value. It is applied as a signed number with a leading 0 bit.
- Gain pipeline: gain is registered one cycle ahead of its use, so there is no chained multiply in one cycle.
  - GAIN (1 cycle) computes g_0.
  - MAC (NUM_BANDS cycles): cycle j accumulates band j using g_j, and computes g_{j+1} when j<NUM_BANDS-1.
- Per-band term: t = (band * g) >>> (POT_W-1). A gain of 2^(POT_W-1) is unity.
  - t saturates to DATA_W signed range; saturation sets that channel's clip flag.
- Accumulator width is DATA_W+clog2(NUM_BANDS)+1, with no internal overflow.
- VOL (1 cycle):
  - Saturate the accumulator to DATA_W and set clip on saturation.
  - Compute y = (sum_sat * {0,volume}) >>> POT_W, an arithmetic shift (floors toward −∞). y always fits DATA_W.
- DONE (1 cycle):
  - Register y into aud_out_*, register the clip flags, and pulse out_vld.
  - Return to IDLE. busy is 0 in DONE.
- vld while busy=1 (GAIN/MAC/VOL): the sample is dropped and overrun pulses the next cycle. vld in DONE or IDLE is accepted.
- Left and right are computed in lockstep with the shared gain; the channels are fully independent otherwise.
- Inputs may change freely after the capture edge without affecting the result in progress.

## Timing
- Reset values: aud_out_lft/rght=0, clip_*=0, out_vld=0, busy=0, overrun=0, FSM=IDLE, idx=0.
- Capture edge E0 is the edge where vld=1 in IDLE/DONE.
- busy=1 from after E0 through VOL.
- out_vld is high for exactly the one cycle after edge E0+NUM_BANDS+3. For NUM_BANDS=5 that is 8 edges after capture.
- Maximum throughput is one sample every NUM_BANDS+3 cycles.
- Reset mid-operation aborts immediately: no out_vld, outputs return to reset values.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Unity:
  - Setup: all pots 0xB51 (g=2048), band0_lft=1000, others 0, band0_rght=−1000, volume 0xFFF, one vld.
  - Required: aud_out_lft=999, aud_out_rght=−1000, clip=0.
  - out_vld high exactly 8 cycles after the capture edge; busy low in that cycle.
- Saturation:
  - Setup: pots 0xFFF (g=4094), all left bands 16384, all right bands −16384, volume 0xFFF.
  - Required: aud_out_lft=32759, aud_out_rght=−32760, clip_lft=clip_rght=1.
- Zero gain: all pots 0, bands 0x7FFF, volume 0xFFF → outputs 0, clip=0. Then volume 0 with unity pots → outputs 0.
- Overrun/back-to-back:
  - vld at capture and again 3 cycles later → one overrun pulse and a single out_vld.
  - vld in the out_vld cycle is accepted; the next out_vld follows 8 cycles later with the new data.
- Reset mid-op: assert rst_n=0 during MAC → all outputs 0 and no out_vld. After release, a new vld produces a correct result.
- Snapshot: change band_lft and pot on the cycle after capture → the result matches the captured values.
